train_section_arbiter: RTL

//  Arbitrates one shared single-line track section between N_TRAINS train controllers.

---
 rtl/train_section_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/train_section_arbiter.sv
// train_section_arbiter: round-robin ownership of one single-line track section,
// with a red clearance hold between occupancies, an entry timeout and a latched fault.
module train_section_arbiter #(
  parameter int N_TRAINS       = 4,
  parameter int CLEAR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_TRAINS-1:0] i_req,
  input  logic [N_TRAINS-1:0] i_done,
  input  logic                i_sensor_occ,
  input  logic                i_fault_clr,
  output logic [N_TRAINS-1:0] o_grant,
  output logic                o_signal_grn,
  output logic                o_busy,
  output logic                o_fault,
  output logic [2:0]          o_state
);
  localparam int PW = (N_TRAINS > 1) ? $clog2(N_TRAINS) : 1;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_OCC   = 3'd2,
    S_CLEAR = 3'd3,
    S_FAULT = 3'd4
  } state_t;
  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [N_TRAINS-1:0] r_grant, w_grant;
  logic [PW-1:0]       r_rr, w_rr, w_win, w_idx;
  logic                w_found, w_own_req, w_own_done;
  // search starts just after the last winner so every requester gets a turn
  always_comb begin
    w_win   = r_rr;
    w_idx   = r_rr;
    w_found = 1'b0;
    for (int k = 1; k <= N_TRAINS; k++) begin
      w_idx = PW'((int'(r_rr) + k) % N_TRAINS);
      if (!w_found && i_req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end
  assign w_own_req  = i_req[r_rr];
  assign w_own_done = i_done[r_rr];
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_grant = r_grant;
    w_rr    = r_rr;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (i_sensor_occ) w_state = S_FAULT;
        else if (w_found) begin
          w_state = S_GRANT;
          w_grant = N_TRAINS'(1) << w_win;
          w_rr    = w_win;
        end
      end
      S_GRANT: begin
        if (i_sensor_occ) begin
          w_state = S_OCC;
          w_cnt   = '0;
        end else if (!w_own_req || r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state = S_CLEAR;
          w_cnt   = '0;
          w_grant = '0;
        end else w_cnt = r_cnt + 1'b1;
      end
      S_OCC: begin
        if (w_own_done && !i_sensor_occ) begin
          w_state = S_CLEAR;
          w_cnt   = '0;
          w_grant = '0;
        end
      end
      S_CLEAR: begin
        w_grant = '0;
        if (i_sensor_occ) begin
          w_state = S_FAULT;
          w_cnt   = '0;
        end else if (r_cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end else w_cnt = r_cnt + 1'b1;
      end
      S_FAULT: begin
        w_grant = '0;
        if (i_fault_clr && !i_sensor_occ) begin
          w_state = S_CLEAR;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_grant = '0;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_rr    <= PW'(N_TRAINS - 1);
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_grant <= w_grant;
      r_rr    <= w_rr;
    end
  end
  assign o_grant      = r_grant;
  assign o_state      = r_state;
  assign o_signal_grn = (r_state == S_GRANT);
  assign o_busy       = (r_state != S_IDLE);
  assign o_fault      = (r_state == S_FAULT);
endmodule
